ms_dbio_cpu_ctrl: RTL and testbench

Debug-bus (Dbio) target that owns the CPU control register at a fixed Dbio address. It decodes single-cycle Dbio write and read requests from a bus initiator such as the bring-up FSM or the debug link, and turns command bytes into CPU reset, start and halt sequences. Command byte 0x03 resets the CPU and 0x05 starts it. It returns a coherent status snapshot on reads and sits between the Dbio fabric and the CPU core's control pins.

---
 rtl/ms_dbio_cpu_ctrl_pkg.sv | 58 +++++
 rtl/ms_dbio_byte_mask.sv | 16 +
 rtl/ms_dbio_cpu_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ms_dbio_cpu_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_dbio_cpu_ctrl_pkg.sv
// Shared definitions for the Dbio CPU control target: command bits, states, status layout.
package ms_dbio_cpu_ctrl_pkg;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned BYTES     = 8;
    localparam int unsigned IP_W      = 32;
    localparam int unsigned IP_LSB    = 8;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned RST_CNT_W = 8;
    localparam int unsigned CMD_W     = 8;

    localparam int unsigned CMD_BIT_VALID = 0;
    localparam int unsigned CMD_BIT_RESET = 1;
    localparam int unsigned CMD_BIT_START = 2;
    localparam int unsigned CMD_BIT_HALT  = 3;

    localparam logic [CMD_W-1:0] CMD_RESET = 8'h03;
    localparam logic [CMD_W-1:0] CMD_START = 8'h05;

    localparam int unsigned ST_IDX_STOPPED   = 0;
    localparam int unsigned ST_IDX_RESETTING = 1;
    localparam int unsigned ST_IDX_RUNNING   = 2;
    localparam int unsigned ST_IDX_HALTING   = 3;

    // One-hot encoding; bit position equals the state index above.
    typedef enum logic [3:0] {
        ST_STOPPED   = 4'b0001,
        ST_RESETTING = 4'b0010,
        ST_RUNNING   = 4'b0100,
        ST_HALTING   = 4'b1000
    } state_t;

    localparam int unsigned STS_STATE_LSB = 0;
    localparam int unsigned STS_PEND_BIT  = 4;
    localparam int unsigned STS_ERR_BIT   = 5;
    localparam int unsigned STS_CMD_LSB   = 8;
    localparam int unsigned STS_CNT_LSB   = 32;

    function automatic logic [DATA_W-1:0] status_word(
        input state_t           st,
        input logic             pend,
        input logic             err,
        input logic [CMD_W-1:0] cmd,
        input logic [CNT_W-1:0] cnt
    );
        logic [DATA_W-1:0] w;
        w = '0;
        w[STS_STATE_LSB +: 4]   = st;
        w[STS_PEND_BIT]         = pend;
        w[STS_ERR_BIT]          = err;
        w[STS_CMD_LSB +: CMD_W] = cmd;
        w[STS_CNT_LSB +: CNT_W] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/ms_dbio_byte_mask.sv
// Valid-byte mask from a Dbio byte count; counts above eight saturate to all bytes.
module ms_dbio_byte_mask
    import ms_dbio_cpu_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [BYTES-1:0] mask_c
);

    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (32'(idx) > i) mask_c[i] = 1'b1;
        end
    end

endmodule

// File: rtl/ms_dbio_cpu_ctrl.sv
// Dbio target owning the CPU control register: decodes command writes into
// reset/start/halt sequences and serves snapshot-based status reads.
module ms_dbio_cpu_ctrl
    import ms_dbio_cpu_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CAddr    = 12'h000,
    parameter int unsigned       CRstLen  = 8,
    parameter logic [IP_W-1:0]   CStartIp = 32'h0
) (
    input  logic              AClkH,
    input  logic              AResetHN,
    input  logic              AClkHEn,
    input  logic [ADDR_W-1:0] ADbioAddr,
    input  logic [DATA_W-1:0] ADbioMosi,
    input  logic [IDX_W-1:0]  ADbioMosiIdx,
    input  logic [IDX_W-1:0]  ADbioMisoIdx,
    input  logic              ADbioMosi1st,
    input  logic              ADbioMiso1st,
    output logic [DATA_W-1:0] ADbioMiso,
    output logic              AMisoValid,
    output logic              ACpuRst,
    output logic              ACpuStart,
    output logic [IP_W-1:0]   ACpuStartIp,
    output logic              ACpuRun,
    output logic              AHaltReq,
    input  logic              ACpuHaltAck
);

    state_t                 state_q, state_d;
    logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic                   pend_q, pend_d;
    logic [IP_W-1:0]        pend_ip_q, pend_ip_d;
    logic                   err_q, err_d;
    logic [CMD_W-1:0]       cmd_q, cmd_d;
    logic [CNT_W-1:0]       run_cnt_q, run_cnt_d;
    logic [DATA_W-1:0]      snap_q, snap_d;
    logic [IP_W-1:0]        ip_q, ip_d;
    logic                   start_q, start_d;
    logic                   rst_q, rst_d;
    logic                   run_q, run_d;
    logic                   halt_q, halt_d;
    logic [DATA_W-1:0]      miso_q, miso_d;
    logic                   valid_q, valid_d;

    logic [BYTES-1:0]       wmask_c, rmask_c;
    logic [DATA_W-1:0]      rd_keep;
    logic                   hit, wr, rd, do_rst, do_start, do_halt;
    logic [CMD_W-1:0]       wr_cmd;
    logic [IP_W-1:0]        wr_ip;
    logic [DATA_W-1:0]      status, rd_word;
    logic                   unused_ok;

    ms_dbio_byte_mask u_wmask (.idx(ADbioMosiIdx), .mask_c(wmask_c));
    ms_dbio_byte_mask u_rmask (.idx(ADbioMisoIdx), .mask_c(rmask_c));

    assign hit      = (ADbioAddr == CAddr);
    assign wr       = hit && wmask_c[0];
    assign rd       = hit && rmask_c[0];
    assign wr_cmd   = ADbioMosi[CMD_W-1:0];
    assign wr_ip    = wmask_c[4] ? ADbioMosi[IP_LSB +: IP_W] : CStartIp;
    assign do_rst   = wr && wr_cmd[CMD_BIT_VALID] && wr_cmd[CMD_BIT_RESET];
    assign do_start = wr && wr_cmd[CMD_BIT_VALID] && wr_cmd[CMD_BIT_START];
    assign do_halt  = wr && wr_cmd[CMD_BIT_VALID] && wr_cmd[CMD_BIT_HALT];
    assign status   = status_word(state_q, pend_q, err_q, cmd_q, run_cnt_q);
    assign rd_word  = ADbioMiso1st ? status : snap_q;
    assign unused_ok = &{1'b0, ADbioMosi1st, ADbioMosi[DATA_W-1:IP_LSB+IP_W],
                         wmask_c[BYTES-1:5], wmask_c[3:1]};

    always_comb begin
        rd_keep = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            rd_keep[i*8 +: 8] = {8{rmask_c[i]}};
        end
    end

    // Next-state: autonomous progress first, then the command byte, reset last so it dominates.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        pend_d    = pend_q;
        pend_ip_d = pend_ip_q;
        err_d     = err_q;
        cmd_d     = cmd_q;
        run_cnt_d = run_cnt_q;
        snap_d    = snap_q;
        ip_d      = ip_q;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        miso_d    = '0;

        if (rd) begin
            snap_d  = rd_word;
            miso_d  = rd_word & rd_keep;
            valid_d = 1'b1;
        end
        if (wr) cmd_d = wr_cmd;

        case (state_q)
            ST_RUNNING:   run_cnt_d = run_cnt_q + CNT_W'(1);
            ST_RESETTING: begin
                if (rst_cnt_q == '0) state_d = ST_STOPPED;
                else                 rst_cnt_d = rst_cnt_q - RST_CNT_W'(1);
            end
            ST_HALTING:   if (ACpuHaltAck) state_d = ST_STOPPED;
            ST_STOPPED: begin
                if (pend_q && !do_rst) begin
                    state_d   = ST_RUNNING;
                    start_d   = 1'b1;
                    ip_d      = pend_ip_q;
                    pend_d    = 1'b0;
                    run_cnt_d = '0;
                end
            end
            default: state_d = ST_STOPPED;
        endcase

        if (do_start) begin
            if (do_rst || state_q == ST_RESETTING) begin
                pend_d    = 1'b1;
                pend_ip_d = wr_ip;
            end else if (state_q == ST_STOPPED) begin
                state_d   = ST_RUNNING;
                start_d   = 1'b1;
                ip_d      = wr_ip;
                pend_d    = 1'b0;
                run_cnt_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (do_halt && !do_rst) begin
            if (state_q == ST_RUNNING) state_d = ST_HALTING;
            else                       err_d   = 1'b1;
        end

        if (do_rst) begin
            state_d   = ST_RESETTING;
            rst_cnt_d = RST_CNT_W'(CRstLen - 1);
            err_d     = 1'b0;
        end

        rst_d  = (state_d == ST_RESETTING);
        run_d  = (state_d == ST_RUNNING) || (state_d == ST_HALTING);
        halt_d = (state_d == ST_HALTING);
    end

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            state_q   <= ST_STOPPED;
            rst_cnt_q <= '0;
            pend_q    <= 1'b0;
            pend_ip_q <= '0;
            err_q     <= 1'b0;
            cmd_q     <= '0;
            run_cnt_q <= '0;
            snap_q    <= '0;
            ip_q      <= '0;
            start_q   <= 1'b0;
            rst_q     <= 1'b0;
            run_q     <= 1'b0;
            halt_q    <= 1'b0;
            miso_q    <= '0;
            valid_q   <= 1'b0;
        end else if (AClkHEn) begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            pend_q    <= pend_d;
            pend_ip_q <= pend_ip_d;
            err_q     <= err_d;
            cmd_q     <= cmd_d;
            run_cnt_q <= run_cnt_d;
            snap_q    <= snap_d;
            ip_q      <= ip_d;
            start_q   <= start_d;
            rst_q     <= rst_d;
            run_q     <= run_d;
            halt_q    <= halt_d;
            miso_q    <= miso_d;
            valid_q   <= valid_d;
        end
    end

    assign ADbioMiso   = miso_q;
    assign AMisoValid  = valid_q;
    assign ACpuRst     = rst_q;
    assign ACpuStart   = start_q;
    assign ACpuStartIp = ip_q;
    assign ACpuRun     = run_q;
    assign AHaltReq    = halt_q;

endmodule

// File: tb/tb_ms_dbio_cpu_ctrl.sv
// Bench for ms_dbio_cpu_ctrl: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the command and status rules.
`timescale 1ns/1ps
module tb_ms_dbio_cpu_ctrl;

    localparam logic [11:0] CADDR  = 12'h000;
    localparam int          RSTLEN = 8;
    localparam logic [31:0] SIP    = 32'hA5A5_1000;
    localparam int S_STOP = 0, S_RSTG = 1, S_RUN = 2, S_HALT = 3;

    logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1;
    logic [11:0] addr = CADDR;
    logic [63:0] mosi = '0;
    logic [3:0]  mosi_idx = '0, miso_idx = '0;
    logic        mosi_1st = 1'b0, miso_1st = 1'b0, halt_ack = 1'b0;
    logic [63:0] miso;
    logic        miso_valid, cpu_rst, cpu_start, cpu_run, halt_req;
    logic [31:0] cpu_start_ip;

    int n_checks = 0, n_pass = 0;

    // Reference model state (state numbers are the status-word state indices)
    int          m_st, m_left;
    logic        m_pend, m_err, m_start, m_valid;
    logic [31:0] m_pend_ip, m_ip, m_run;
    logic [7:0]  m_cmd;
    logic [63:0] m_snap, m_miso;

    ms_dbio_cpu_ctrl #(.CAddr(CADDR), .CRstLen(RSTLEN), .CStartIp(SIP)) dut (
        .AClkH(clk), .AResetHN(rst_n), .AClkHEn(clk_en), .ADbioAddr(addr),
        .ADbioMosi(mosi), .ADbioMosiIdx(mosi_idx), .ADbioMisoIdx(miso_idx),
        .ADbioMosi1st(mosi_1st), .ADbioMiso1st(miso_1st), .ADbioMiso(miso),
        .AMisoValid(miso_valid), .ACpuRst(cpu_rst), .ACpuStart(cpu_start),
        .ACpuStartIp(cpu_start_ip), .ACpuRun(cpu_run), .AHaltReq(halt_req),
        .ACpuHaltAck(halt_ack)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = S_STOP; m_left = 0; m_pend = 0; m_err = 0; m_start = 0; m_valid = 0;
        m_pend_ip = '0; m_ip = '0; m_run = '0; m_cmd = '0; m_snap = '0; m_miso = '0;
    endtask

    function automatic logic [63:0] status_now();
        return (64'(m_run) << 32) | (64'(m_cmd) << 8) | (64'(m_err) << 5)
             | (64'(m_pend) << 4) | 64'(1 << m_st);
    endfunction

    function automatic logic [63:0] keep_bytes(input int n);
        if (n >= 8) return '1;
        return (64'd1 << (8 * n)) - 64'd1;
    endfunction

    task automatic fire(input logic [31:0] ip);
        m_st = S_RUN; m_start = 1; m_ip = ip; m_pend = 0; m_run = '0;
    endtask

    // One enabled clock of the model, evaluated from the pre-edge state.
    task automatic model_step(input logic e, input logic [11:0] a, input logic [63:0] d,
                              input int wi, input int ri, input logic r1, input logic ack);
        logic [63:0] sts;
        logic [7:0]  c;
        logic [31:0] ip;
        logic        hit, v, rb, sb, hb;
        int          st0;
        if (!e) return;
        hit = (a == CADDR);
        sts = status_now();
        st0 = m_st;
        m_start = 0; m_valid = 0; m_miso = '0;
        if (hit && ri != 0) begin
            if (r1) m_snap = sts;
            m_miso  = m_snap & keep_bytes(ri);
            m_valid = 1;
        end
        if (st0 == S_RUN) m_run = m_run + 32'd1;
        if (st0 == S_RSTG) begin
            m_left = m_left - 1;
            if (m_left == 0) m_st = S_STOP;
        end
        if (st0 == S_HALT && ack) m_st = S_STOP;
        c  = d[7:0];
        ip = (wi >= 5) ? d[39:8] : SIP;
        if (hit && wi != 0) m_cmd = c;
        v  = hit && (wi != 0) && c[0];
        rb = v && c[1]; sb = v && c[2]; hb = v && c[3];
        if (rb) begin
            m_st = S_RSTG; m_left = RSTLEN; m_err = 0;
            if (sb) begin m_pend = 1; m_pend_ip = ip; end
        end else begin
            if (sb) begin
                if (st0 == S_STOP)      fire(ip);
                else if (st0 == S_RSTG) begin m_pend = 1; m_pend_ip = ip; end
                else                    m_err = 1;
            end else if (st0 == S_STOP && m_pend) begin
                fire(m_pend_ip);
            end
            if (hb) begin
                if (st0 == S_RUN) m_st = S_HALT;
                else              m_err = 1;
            end
        end
    endtask

    function automatic logic [100:0] dut_out();
        return {cpu_rst, cpu_run, halt_req, cpu_start, miso_valid, cpu_start_ip, miso};
    endfunction

    function automatic logic [100:0] model_out();
        return {m_st == S_RSTG, (m_st == S_RUN) || (m_st == S_HALT), m_st == S_HALT,
                m_start, m_valid, m_ip, m_miso};
    endfunction

    task automatic cyc(input logic e, input logic [11:0] a, input logic [63:0] d,
                       input logic [3:0] wi, input logic [3:0] ri, input logic r1,
                       input logic ack);
        clk_en = e; addr = a; mosi = d; mosi_idx = wi; miso_idx = ri;
        miso_1st = r1; halt_ack = ack; mosi_1st = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_step(e, a, d, int'(wi), int'(ri), r1, ack);
        #1;
        clk_en = 1'b1; addr = CADDR; mosi = '0; mosi_idx = '0; miso_idx = '0;
        miso_1st = 1'b0; halt_ack = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b1, CADDR, 64'h0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [63:0] d, input logic [3:0] wi);
        cyc(1'b1, CADDR, d, wi, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] ri, input logic r1);
        cyc(1'b1, CADDR, 64'h0, 4'd0, ri, r1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        n_checks++;
        if (dut_out() !== '0) $display("FAIL reset_outputs: got %h want 0", dut_out());
        else n_pass++;
        rd(4'd8, 1'b1);
        n_checks++;
        if ({miso_valid, miso} !== {1'b1, 64'h1}) $display("FAIL reset_status: got %b %h want 1 %h", miso_valid, miso, 64'h1);
        else n_pass++;
        idle();
        n_checks++;
        if ({miso_valid, miso} !== 65'h0) $display("FAIL read_valid_once: got %b %h want 0 0", miso_valid, miso);
        else n_pass++;
    endtask

    task automatic test_reset_pulse();
        int hi = 0;
        wr(64'h03, 4'd1);
        if (cpu_rst) hi++;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) cyc(1'b1, 12'h100, 64'h05, 4'd1, 4'd0, 1'b0, 1'b0);
            else idle();
            if (cpu_rst) hi++;
            n_checks++;
            if (dut_out() !== model_out()) $display("FAIL rst_pulse cyc %0d: got %h want %h", i, dut_out(), model_out());
            else n_pass++;
        end
        n_checks++;
        if (hi != RSTLEN) $display("FAIL rst_len: got %0d want %0d", hi, RSTLEN);
        else n_pass++;
        rd(4'd8, 1'b1);
        n_checks++;
        if (miso !== 64'h0301) $display("FAIL foreign_addr: got %h want %h", miso, 64'h0301);
        else n_pass++;
    endtask

    task automatic test_start();
        logic [63:0] d;
        d = {24'h0, 32'($urandom()), 8'h05};
        wr(d, 4'd1);
        n_checks++;
        if ({cpu_start, cpu_run, cpu_start_ip} !== {1'b1, 1'b1, SIP}) $display("FAIL start_default_ip: got %b%b %h want 11 %h", cpu_start, cpu_run, cpu_start_ip, SIP);
        else n_pass++;
        idle();
        n_checks++;
        if (dut_out() !== model_out() || cpu_start !== 1'b0) $display("FAIL start_one_cycle: got %h want %h", dut_out(), model_out());
        else n_pass++;
        wr(64'h05, 4'd1);
        idle();
        rd(4'd8, 1'b1);
        n_checks++;
        if (miso[15:0] !== 16'h0524) $display("FAIL start_while_running_err: got %h want %h", miso[15:0], 16'h0524);
        else n_pass++;
        n_checks++;
        if (dut_out() !== model_out()) $display("FAIL start_status: got %h want %h", dut_out(), model_out());
        else n_pass++;
    endtask

    task automatic test_pending();
        int          fire_k = -1;
        logic [31:0] ip_seen = '0, ip;
        int          wi;
        wr({24'h0, 32'($urandom()), 8'h07}, 4'($urandom_range(1, 4)));
        for (int k = 1; k <= 20; k++) begin
            idle();
            if (cpu_start && fire_k < 0) begin fire_k = k; ip_seen = cpu_start_ip; end
            n_checks++;
            if (dut_out() !== model_out()) $display("FAIL pending cyc %0d: got %h want %h", k, dut_out(), model_out());
            else n_pass++;
        end
        n_checks++;
        if (fire_k != RSTLEN + 1 || ip_seen !== SIP) $display("FAIL pending_fire: got k=%0d ip=%h want k=%0d ip=%h", fire_k, ip_seen, RSTLEN + 1, SIP);
        else n_pass++;
        for (int j = 0; j < 2; j++) begin
            wr(64'h03, 4'd1);
            repeat (RSTLEN + 1) idle();
            ip = (j == 0) ? 32'h1234_5678 : 32'($urandom());
            wi = (j == 0) ? 5 : $urandom_range(5, 8);
            wr({24'h0, ip, 8'h05}, 4'(wi));
            n_checks++;
            if ({cpu_start, cpu_start_ip} !== {1'b1, ip}) $display("FAIL start_ip %0d: got %b %h want 1 %h", j, cpu_start, cpu_start_ip, ip);
            else n_pass++;
        end
        idle();
        n_checks++;
        if (dut_out() !== model_out()) $display("FAIL ip_held: got %h want %h", dut_out(), model_out());
        else n_pass++;
    endtask

    task automatic test_halt();
        wr(64'h09, 4'd1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({halt_req, cpu_run} !== 2'b11) $display("FAIL halt_req %0d: got %b%b want 11", i, halt_req, cpu_run);
            else n_pass++;
            if (i < 2) idle();
        end
        cyc(1'b1, CADDR, 64'h0, 4'd0, 4'd0, 1'b0, 1'b1);
        n_checks++;
        if ({halt_req, cpu_run} !== 2'b00 || dut_out() !== model_out()) $display("FAIL halt_done: got %h want %h", dut_out(), model_out());
        else n_pass++;
    endtask

    task automatic test_read_snapshot();
        wr(64'h05, 4'd1);
        repeat (5) idle();
        rd(4'd2, 1'b1);
        n_checks++;
        if (miso[63:16] !== 48'h0 || dut_out() !== model_out()) $display("FAIL read_mask2: got %h want %h", dut_out(), model_out());
        else n_pass++;
        repeat (4) idle();
        rd(4'd8, 1'b0);
        n_checks++;
        if (miso[63:32] !== 32'd5) $display("FAIL snapshot_counter: got %0d want 5", miso[63:32]);
        else n_pass++;
        n_checks++;
        if (dut_out() !== model_out()) $display("FAIL snapshot_reuse: got %h want %h", dut_out(), model_out());
        else n_pass++;
    endtask

    task automatic test_clken();
        wr(64'h03, 4'd1);
        repeat (RSTLEN + 1) idle();
        wr(64'h05, 4'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, CADDR, 64'h03, 4'd1, 4'd8, 1'b1, 1'b0);
            n_checks++;
            if ({cpu_start, cpu_rst, miso_valid} !== 3'b100) $display("FAIL clken_freeze %0d: got %b%b%b want 100", i, cpu_start, cpu_rst, miso_valid);
            else n_pass++;
        end
        idle();
        n_checks++;
        if ({cpu_start, cpu_run} !== 2'b01 || dut_out() !== model_out()) $display("FAIL clken_resume: got %h want %h", dut_out(), model_out());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int starts = 0;
        wr(64'h07, 4'd1);
        repeat (3) idle();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_out() !== '0) $display("FAIL async_reset: got %h want 0", dut_out());
        else n_pass++;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (cpu_start) starts++;
        end
        rd(4'd8, 1'b1);
        n_checks++;
        if (starts != 0 || miso !== 64'h1) $display("FAIL async_abort: got starts=%0d status=%h want 0 %h", starts, miso, 64'h1);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] cmds [9];
        logic [63:0] d;
        logic [11:0] a;
        logic [3:0]  wi, ri;
        int          bad = 0;
        cmds = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D, 8'h04, 8'hF5};
        for (int i = 0; i < 400; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? 12'($urandom()) : CADDR;
            d  = {32'($urandom()), 32'($urandom())};
            d[7:0] = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : cmds[$urandom_range(0, 8)];
            wi = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'd0;
            ri = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'd0;
            cyc(1'($urandom_range(0, 9) != 0), a, d, wi, ri, 1'($urandom_range(0, 1)),
                1'(m_st == S_HALT && $urandom_range(0, 3) == 0));
            n_checks++;
            if (dut_out() !== model_out()) begin
                bad++;
                if (bad <= 5) $display("FAIL random cyc %0d: got %h want %h", i, dut_out(), model_out());
            end else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_pulse();
        test_start();
        test_pending();
        test_halt();
        test_read_snapshot();
        test_clken();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
